core_ma_lsu_generate_req: RTL

- Request side of the memory-access LSU. Takes one load/store from the MA stage and issues it on Avalon master port m0 as one or two word-aligned beats.
- Splits accesses that cross a 32-bit boundary, and generates the per-beat byte enables and lane-shifted write data.
- The downstream read-data generator merges the returned words using the same mem_addr[1:0] and mem_op_data_len.

---
 rtl/core_ma_lsu_generate_req.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/core_ma_lsu_generate_req.sv
// ---------------------------------------------------------------------------
// core_ma_lsu_generate_req
//
// Request side of the memory-access LSU. One load/store from the MA stage is
// latched and issued on Avalon master port m0 as one or two word-aligned
// beats. An access that crosses a 32-bit word boundary is split into two
// consecutive beats. Each beat carries its own byte enables and lane-shifted
// write data. The downstream read-data generator merges the returned words
// with the same mem_addr[1:0] / mem_op_data_len, so the split rule here must
// stay identical to the one it uses.
//
// Parameters:
//   ADDR_WIDTH  byte-address width of mem_addr / avl_m0_address (32)
//   DATA_WIDTH  bus data width; only 32 is supported
//
// Ports:
//   clk                  single clock
//   rest                 synchronous reset, active-high
//   mem_req_valid        request present
//   mem_req_ready        block can accept a request (high only in IDLE)
//   mem_read             load request
//   mem_write            store request (wins when both are set)
//   mem_addr             byte address
//   mem_op_data_len      bytes to transfer: 1, 2 or 4 (others act as 4)
//   mem_write_data       store data, right-aligned
//   mem_req_done         one-cycle pulse when the last beat is accepted
//   mem_req_split        latched: the current request uses two beats
//   avl_m0_address       word-aligned beat address
//   avl_m0_byte_enable   byte lanes of the beat
//   avl_m0_read          read strobe
//   avl_m0_write         write strobe
//   avl_m0_write_data    lane-aligned write data
//   avl_m0_wait_request  slave stall
//   mem_misalign_err     only with CORE_LSU_MISALIGN_EXCEPTION_EN
//
// Optional feature, macro CORE_LSU_MISALIGN_EXCEPTION_EN:
//   When defined, a request that would need two beats is accepted but issues
//   no bus beat; mem_misalign_err pulses for one cycle the cycle after accept
//   and the FSM stays in IDLE. When undefined the port does not exist and
//   split accesses run as two beats.
// ---------------------------------------------------------------------------
module core_ma_lsu_generate_req #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rest,
  input  logic                  mem_req_valid,
  output logic                  mem_req_ready,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [2:0]            mem_op_data_len,
  input  logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_req_done,
  output logic                  mem_req_split,
  output logic [ADDR_WIDTH-1:0] avl_m0_address,
  output logic [3:0]            avl_m0_byte_enable,
  output logic                  avl_m0_read,
  output logic                  avl_m0_write,
  output logic [DATA_WIDTH-1:0] avl_m0_write_data,
  input  logic                  avl_m0_wait_request
`ifdef CORE_LSU_MISALIGN_EXCEPTION_EN
  ,
  output logic                  mem_misalign_err
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  // Registered bus outputs and status
  logic [ADDR_WIDTH-1:0] r_address;
  logic [3:0]            r_byteEnable;
  logic [DATA_WIDTH-1:0] r_writeData;
  logic                  r_read;
  logic                  r_write;
  logic                  r_done;
  logic                  r_split;

  // Second beat, prepared at accept time so BEAT0 -> BEAT1 is a plain copy
  logic [ADDR_WIDTH-1:0] r_beat1Address;
  logic [3:0]            r_beat1ByteEnable;
  logic [DATA_WIDTH-1:0] r_beat1WriteData;

  // Next-state values from the FSM's combinational half
  logic [ADDR_WIDTH-1:0] w_addressNext;
  logic [3:0]            w_byteEnableNext;
  logic [DATA_WIDTH-1:0] w_writeDataNext;
  logic                  w_readNext;
  logic                  w_writeNext;
  logic                  w_doneNext;
  logic                  w_splitNext;
  logic [ADDR_WIDTH-1:0] w_beat1AddressNext;
  logic [3:0]            w_beat1ByteEnableNext;
  logic [DATA_WIDTH-1:0] w_beat1WriteDataNext;

  // Request decode
  logic                    w_accept;
  logic                    w_anyOp;
  logic [1:0]              w_off;
  logic [2:0]              w_lenBytes;
  logic [3:0]              w_lenMask;
  logic [7:0]              w_be8;
  logic [2*DATA_WIDTH-1:0] w_wd64;
  logic                    w_split;
  logic                    w_trap;
  logic [ADDR_WIDTH-1:0]   w_word0Addr;
  logic [ADDR_WIDTH-1:0]   w_word1Addr;

  assign mem_req_ready      = (r_state == IDLE);
  assign mem_req_done       = r_done;
  assign mem_req_split      = r_split;
  assign avl_m0_address     = r_address;
  assign avl_m0_byte_enable = r_byteEnable;
  assign avl_m0_read        = r_read;
  assign avl_m0_write       = r_write;
  assign avl_m0_write_data  = r_writeData;

  assign w_accept = mem_req_valid && mem_req_ready;
  // valid with neither read nor write is accepted but silently dropped
  assign w_anyOp  = mem_read || mem_write;
  assign w_off    = mem_addr[1:0];

  // Illegal lengths (0, 3, 5-7) fall into the default and act as a word
  always_comb begin
    w_lenBytes = 3'd4;
    w_lenMask  = 4'b1111;
    case (mem_op_data_len)
      3'd1: begin
        w_lenBytes = 3'd1;
        w_lenMask  = 4'b0001;
      end
      3'd2: begin
        w_lenBytes = 3'd2;
        w_lenMask  = 4'b0011;
      end
      default: begin
        w_lenBytes = 3'd4;
        w_lenMask  = 4'b1111;
      end
    endcase
  end

  // Lanes and data across a two-word window; the low word is beat0, the high
  // word is beat1. The sum off+len is at most 7, so 3 bits cannot overflow.
  assign w_be8       = {4'b0000, w_lenMask} << w_off;
  assign w_wd64      = {{DATA_WIDTH{1'b0}}, mem_write_data} << {w_off, 3'b000};
  assign w_split     = (({1'b0, w_off} + w_lenBytes) > 3'd4);
  assign w_word0Addr = {mem_addr[ADDR_WIDTH-1:2], 2'b00};
  assign w_word1Addr = w_word0Addr + {{(ADDR_WIDTH-3){1'b0}}, 3'b100};

`ifdef CORE_LSU_MISALIGN_EXCEPTION_EN
  assign w_trap = w_split;
`else
  assign w_trap = 1'b0;
`endif

  // State register and all registered outputs. Reset clears every output so
  // an aborted transaction leaves no strobe behind and never reports done.
  always_ff @(posedge clk) begin
    if (rest) begin
      r_state           <= IDLE;
      r_address         <= '0;
      r_byteEnable      <= '0;
      r_writeData       <= '0;
      r_read            <= 1'b0;
      r_write           <= 1'b0;
      r_done            <= 1'b0;
      r_split           <= 1'b0;
      r_beat1Address    <= '0;
      r_beat1ByteEnable <= '0;
      r_beat1WriteData  <= '0;
    end else begin
      r_state           <= w_stateNext;
      r_address         <= w_addressNext;
      r_byteEnable      <= w_byteEnableNext;
      r_writeData       <= w_writeDataNext;
      r_read            <= w_readNext;
      r_write           <= w_writeNext;
      r_done            <= w_doneNext;
      r_split           <= w_splitNext;
      r_beat1Address    <= w_beat1AddressNext;
      r_beat1ByteEnable <= w_beat1ByteEnableNext;
      r_beat1WriteData  <= w_beat1WriteDataNext;
    end
  end

  // Next-state and next-output logic. Everything holds by default, which is
  // what keeps the bus outputs frozen while the slave asserts wait_request.
  always_comb begin
    w_stateNext           = r_state;
    w_addressNext         = r_address;
    w_byteEnableNext      = r_byteEnable;
    w_writeDataNext       = r_writeData;
    w_readNext            = r_read;
    w_writeNext           = r_write;
    w_doneNext            = 1'b0;
    w_splitNext           = r_split;
    w_beat1AddressNext    = r_beat1Address;
    w_beat1ByteEnableNext = r_beat1ByteEnable;
    w_beat1WriteDataNext  = r_beat1WriteData;

    unique case (r_state)
      IDLE: begin
        if (w_accept && w_anyOp) begin
          w_splitNext = w_split;
          // A trapped misaligned request is consumed here without a beat
          if (!w_trap) begin
            w_stateNext           = BEAT0;
            w_addressNext         = w_word0Addr;
            w_byteEnableNext      = w_be8[3:0];
            w_writeDataNext       = w_wd64[DATA_WIDTH-1:0];
            w_writeNext           = mem_write;
            w_readNext            = mem_read && !mem_write;
            w_beat1AddressNext    = w_word1Addr;
            w_beat1ByteEnableNext = w_be8[7:4];
            w_beat1WriteDataNext  = w_wd64[2*DATA_WIDTH-1:DATA_WIDTH];
          end
        end
      end

      BEAT0: begin
        if (!avl_m0_wait_request) begin
          if (r_split) begin
            // Second beat follows back-to-back, strobe stays asserted
            w_stateNext      = BEAT1;
            w_addressNext    = r_beat1Address;
            w_byteEnableNext = r_beat1ByteEnable;
            w_writeDataNext  = r_beat1WriteData;
          end else begin
            w_stateNext = IDLE;
            w_readNext  = 1'b0;
            w_writeNext = 1'b0;
            w_doneNext  = 1'b1;
          end
        end
      end

      BEAT1: begin
        if (!avl_m0_wait_request) begin
          w_stateNext = IDLE;
          w_readNext  = 1'b0;
          w_writeNext = 1'b0;
          w_doneNext  = 1'b1;
        end
      end

      default: begin
        w_stateNext = IDLE;
        w_readNext  = 1'b0;
        w_writeNext = 1'b0;
      end
    endcase
  end

`ifdef CORE_LSU_MISALIGN_EXCEPTION_EN
  logic r_misalignErr;

  // One-cycle error pulse the cycle after a split request is accepted
  always_ff @(posedge clk) begin
    if (rest) begin
      r_misalignErr <= 1'b0;
    end else begin
      r_misalignErr <= w_accept && w_anyOp && w_split;
    end
  end

  assign mem_misalign_err = r_misalignErr;
`endif

endmodule
